// File: rtl/tms34020_bus_arb.sv
// DBUS arbiter for the TMS34020 local bus: CPU memory controller, host interface
// and an internal DRAM refresh sequencer share one bus through one-hot grants.
module tms34020_bus_arb #(
   parameter int ROW_W = 10,
   parameter int CNT_W = 12
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             CE_R,
   input  logic [CNT_W-1:0] REF_PERIOD,
   input  logic             CPU_REQ,
   input  logic             CPU_DONE,
   output logic             CPU_GNT,
   input  logic             HOST_REQ,
   input  logic             HOST_DONE,
   output logic             HOST_GNT,
   input  logic             REF_RDY,
   output logic             REF_CYC,
   output logic [3:0]       REF_CODE,
   output logic [ROW_W-1:0] REF_ROW,
   output logic [1:0]       REF_BACKLOG,
   output logic             BUSY,
   output logic [1:0]       DBG_STATE
);

   // Handshake: a requester holds REQ until granted; the grant stays high until
   // DONE is sampled on a tick, and the grant drops on that same edge.
   typedef enum logic [1:0] {S_IDLE, S_CPU, S_HOST, S_REF} state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [ROW_W-1:0] row_n;
   logic [1:0]       backlog_n;
   logic             host_last, host_last_n;
   logic             tick, inc, dec;

   assign tick      = EN & CE_R;
   assign DBG_STATE = state;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      row_n       = REF_ROW;
      host_last_n = host_last;
      inc         = 1'b0;
      dec         = 1'b0;
      if (tick) begin
         if (REF_PERIOD != '0) begin
            if (cnt <= CNT_W'(1)) begin
               cnt_n = REF_PERIOD;
               inc   = 1'b1;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         case (state)
            S_IDLE: begin
               if (REF_BACKLOG == 2'd3) begin
                  state_n = S_REF;
               end else if (HOST_REQ && !(CPU_REQ && host_last)) begin
                  state_n     = S_HOST;
                  host_last_n = 1'b1;
               end else if (CPU_REQ) begin
                  state_n     = S_CPU;
                  host_last_n = 1'b0;
               end else if (REF_BACKLOG != 2'd0) begin
                  state_n = S_REF;
               end
            end
            S_CPU:  if (CPU_DONE)  state_n = S_IDLE;
            S_HOST: if (HOST_DONE) state_n = S_IDLE;
            S_REF: begin
               if (REF_RDY) begin
                  dec     = 1'b1;
                  row_n   = REF_ROW + ROW_W'(1);
                  state_n = S_IDLE;
               end
            end
            default: state_n = S_IDLE;
         endcase
      end
   end

   // Saturating backlog; a simultaneous inc and dec cancel out.
   always_comb begin
      backlog_n = REF_BACKLOG;
      if (inc && !dec && REF_BACKLOG != 2'd3)
         backlog_n = REF_BACKLOG + 2'd1;
      else if (dec && !inc && REF_BACKLOG != 2'd0)
         backlog_n = REF_BACKLOG - 2'd1;
   end

   // Every *_n equals the current value when there is no tick, so the
   // unconditional update freezes state whenever EN or CE_R is low.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         cnt         <= REF_PERIOD;
         REF_ROW     <= '0;
         REF_BACKLOG <= 2'd0;
         host_last   <= 1'b0;
         CPU_GNT     <= 1'b0;
         HOST_GNT    <= 1'b0;
         REF_CYC     <= 1'b0;
         REF_CODE    <= 4'b1111;
         BUSY        <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         REF_ROW     <= row_n;
         REF_BACKLOG <= backlog_n;
         host_last   <= host_last_n;
         CPU_GNT     <= (state_n == S_CPU);
         HOST_GNT    <= (state_n == S_HOST);
         REF_CYC     <= (state_n == S_REF);
         REF_CODE    <= (state_n == S_REF) ? 4'b0011 : 4'b1111;
         BUSY        <= (state_n != S_IDLE);
      end
   end

endmodule

// File: tb/tb_tms34020_bus_arb.sv
// Directed bench for tms34020_bus_arb: refresh scheduling, host/CPU alternation,
// urgent refresh, inc/dec collision, row wrap (ROW_W=2), reset and freeze.
module tb_tms34020_bus_arb;

   localparam int ROW_W = 2;
   localparam int CNT_W = 12;

   logic             CLK = 1'b0;
   logic             RST, EN, CE_R;
   logic [CNT_W-1:0] REF_PERIOD;
   logic             CPU_REQ, CPU_DONE, CPU_GNT;
   logic             HOST_REQ, HOST_DONE, HOST_GNT;
   logic             REF_RDY, REF_CYC, BUSY;
   logic [3:0]       REF_CODE;
   logic [ROW_W-1:0] REF_ROW;
   logic [1:0]       REF_BACKLOG, DBG_STATE;

   int total = 0;
   int bad   = 0;

   tms34020_bus_arb #(.ROW_W(ROW_W), .CNT_W(CNT_W)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .CE_R(CE_R), .REF_PERIOD(REF_PERIOD),
      .CPU_REQ(CPU_REQ), .CPU_DONE(CPU_DONE), .CPU_GNT(CPU_GNT),
      .HOST_REQ(HOST_REQ), .HOST_DONE(HOST_DONE), .HOST_GNT(HOST_GNT),
      .REF_RDY(REF_RDY), .REF_CYC(REF_CYC), .REF_CODE(REF_CODE),
      .REF_ROW(REF_ROW), .REF_BACKLOG(REF_BACKLOG), .BUSY(BUSY),
      .DBG_STATE(DBG_STATE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock; outputs and new inputs are handled 1 time unit after the edge.
   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   logic [1:0] alt_exp [12] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0,
                                2'd2, 2'd2, 2'd0, 2'd1, 2'd1, 2'd0};
   logic [1:0] bl_exp  [9]  = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin
      RST = 1'b1; EN = 1'b1; CE_R = 1'b1; REF_PERIOD = 12'd5;
      CPU_REQ = 1'b0; CPU_DONE = 1'b0; HOST_REQ = 1'b0; HOST_DONE = 1'b0; REF_RDY = 1'b0;

      // reset and first scheduled refresh
      step(2);
      chk("rst_gnt", {CPU_GNT, HOST_GNT, REF_CYC, BUSY}, 4'b0000);
      chk("rst_code", REF_CODE, 4'b1111);
      chk("rst_row", REF_ROW, 0);
      chk("rst_bl", REF_BACKLOG, 0);
      RST = 1'b0;
      step(4);
      chk("bl_before_expiry", REF_BACKLOG, 0);
      step(1);
      chk("bl_after_5", REF_BACKLOG, 1);
      chk("no_ref_yet", REF_CYC, 0);
      step(1);
      chk("ref_enter", REF_CYC, 1);
      chk("ref_code", REF_CODE, 4'b0011);
      chk("ref_busy", BUSY, 1);
      REF_RDY = 1'b1;
      step(1);
      REF_RDY = 1'b0;
      chk("ref_row1", REF_ROW, 1);
      chk("ref_bl0", REF_BACKLOG, 0);
      chk("ref_exit", REF_CYC, 0);
      chk("ref_code_idle", REF_CODE, 4'b1111);

      // host/CPU alternation with both requests held
      REF_PERIOD = 12'd0;
      CPU_REQ = 1'b1; HOST_REQ = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step(1);
         HOST_DONE = 1'b0; CPU_DONE = 1'b0;
         chk($sformatf("alt%0d", i), {HOST_GNT, CPU_GNT}, alt_exp[i]);
         if (i == 1 || i == 7) HOST_DONE = 1'b1;
         if (i == 4 || i == 10) CPU_DONE = 1'b1;
      end
      CPU_REQ = 1'b0; HOST_REQ = 1'b0;

      // urgent refresh: backlog saturates during a long CPU grant
      REF_PERIOD = 12'd2;
      CPU_REQ = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step(1);
         if (i == 0) HOST_REQ = 1'b1;
         chk($sformatf("sat_bl%0d", i), REF_BACKLOG, bl_exp[i]);
         if (i < 8) chk($sformatf("sat_gnt%0d", i), CPU_GNT, 1);
         if (i == 7) CPU_DONE = 1'b1;
      end
      CPU_DONE = 1'b0;
      chk("sat_cpu_off", CPU_GNT, 0);
      step(1);
      chk("urgent_ref", REF_CYC, 1);
      chk("urgent_no_host", HOST_GNT, 0);
      REF_PERIOD = 12'd0; CPU_REQ = 1'b0; HOST_REQ = 1'b0; REF_RDY = 1'b1;
      step(1);
      chk("drain1_bl", REF_BACKLOG, 2);
      chk("drain1_row", REF_ROW, 2);
      step(1);
      chk("drain2_ref", REF_CYC, 1);
      step(1);
      chk("drain2_bl", REF_BACKLOG, 1);
      chk("drain2_row", REF_ROW, 3);
      step(2);
      chk("drain3_bl", REF_BACKLOG, 0);
      chk("wrap_row", REF_ROW, 0);
      step(1);
      chk("drained_idle", REF_CYC, 0);
      REF_RDY = 1'b0;

      // refresh completion coinciding with interval expiry at backlog 2
      REF_PERIOD = 12'd3; CPU_REQ = 1'b1;
      step(1);
      chk("col_cpu", CPU_GNT, 1);
      chk("col_bl1", REF_BACKLOG, 1);
      step(3);
      chk("col_bl2", REF_BACKLOG, 2);
      CPU_DONE = 1'b1; CPU_REQ = 1'b0;
      step(1);
      CPU_DONE = 1'b0;
      chk("col_cpu_off", CPU_GNT, 0);
      step(1);
      chk("col_ref", REF_CYC, 1);
      REF_RDY = 1'b1;
      step(1);
      REF_RDY = 1'b0;
      chk("col_bl_hold", REF_BACKLOG, 2);
      chk("col_row", REF_ROW, 1);
      chk("col_ref_off", REF_CYC, 0);

      // mid-operation reset while host owns the bus, with CE_R low
      REF_PERIOD = 12'd0; HOST_REQ = 1'b1;
      step(1);
      chk("mr_host", HOST_GNT, 1);
      CE_R = 1'b0; RST = 1'b1;
      step(1);
      chk("mr_host_off", HOST_GNT, 0);
      chk("mr_bl", REF_BACKLOG, 0);
      chk("mr_row", REF_ROW, 0);
      RST = 1'b0; HOST_REQ = 1'b0; CPU_REQ = 1'b1;
      step(1);
      chk("mr_frozen", CPU_GNT, 0);
      CE_R = 1'b1;
      step(1);
      chk("mr_cpu", {HOST_GNT, CPU_GNT}, 2'b01);

      // EN low freezes the grant even with DONE present
      EN = 1'b0; CPU_DONE = 1'b1;
      step(1);
      chk("en_freeze", CPU_GNT, 1);
      EN = 1'b1;
      step(1);
      CPU_DONE = 1'b0; CPU_REQ = 1'b0;
      chk("en_done", {CPU_GNT, BUSY}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
